// File: rtl/pipeline_if_align_pkg.sv
// Shared definitions for the instruction-fetch / RVC realignment stage.
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   NOP_INSTR_DEFAULT : default instruction presented to ID when nothing is valid
//   redir_src_e       : which source (if any) redirects fetch this cycle
//   is_compressed()   : RVC length decode on a 16-bit parcel
package pipeline_if_align_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_EXE,
    REDIR_ID
  } redir_src_e;

  // A parcel whose two low bits are not 2'b11 starts a 16-bit instruction.
  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/pipeline_if_align_rvc_fetch_align.sv
// Halfword buffer plus the RV32IC assembly table.
// Consumes fetched words from the parent's word register and produces at most
// one instruction per advancing cycle.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   advance_i             : stage advances this cycle (enable and no redirect)
//   flush_i               : redirect; empties the buffer
//   flush_offset_i        : target bit 1; first word is entered at its upper half
//   w_valid_i/data/addr   : word register contents
//   w_consume_o           : word register is consumed this cycle
//   issue_valid_o         : an instruction is available this cycle
//   issue_instr_o/pc/next : instruction, its PC and its fall-through PC
module rvc_fetch_align
  import pipeline_if_align_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        advance_i,
  input  logic        flush_i,
  input  logic        flush_offset_i,
  input  logic        w_valid_i,
  input  logic [31:0] w_data_i,
  input  logic [31:0] w_addr_i,
  output logic        w_consume_o,
  output logic        issue_valid_o,
  output logic [31:0] issue_instr_o,
  output logic [31:0] issue_pc_o,
  output logic [31:0] issue_pc_next_o
);

  logic        h_valid_q, h_valid_d;
  logic [15:0] h_data_q,  h_data_d;
  logic [31:0] h_pc_q,    h_pc_d;
  logic        offset_q,  offset_d;
  logic        consume;
  logic [31:0] w_hi_pc;

  assign w_hi_pc = w_addr_i + 32'd2;

  always_comb begin
    h_valid_d       = h_valid_q;
    h_data_d        = h_data_q;
    h_pc_d          = h_pc_q;
    offset_d        = offset_q;
    consume         = 1'b0;
    issue_valid_o   = 1'b0;
    issue_instr_o   = NOP_INSTR;
    issue_pc_o      = h_pc_q;
    issue_pc_next_o = h_pc_q + 32'd2;

    if (!h_valid_q) begin
      if (w_valid_i) begin
        consume   = 1'b1;
        if (offset_q) begin
          // Misaligned entry: the low half precedes the target, drop it.
          h_valid_d = 1'b1;
          h_data_d  = w_data_i[31:16];
          h_pc_d    = w_hi_pc;
          offset_d  = 1'b0;
        end else if (is_compressed(w_data_i[15:0])) begin
          issue_valid_o   = 1'b1;
          issue_instr_o   = {16'h0000, w_data_i[15:0]};
          issue_pc_o      = w_addr_i;
          issue_pc_next_o = w_hi_pc;
          h_valid_d       = 1'b1;
          h_data_d        = w_data_i[31:16];
          h_pc_d          = w_hi_pc;
        end else begin
          issue_valid_o   = 1'b1;
          issue_instr_o   = w_data_i;
          issue_pc_o      = w_addr_i;
          issue_pc_next_o = w_addr_i + 32'd4;
        end
      end
    end else if (is_compressed(h_data_q)) begin
      issue_valid_o   = 1'b1;
      issue_instr_o   = {16'h0000, h_data_q};
      issue_pc_o      = h_pc_q;
      issue_pc_next_o = h_pc_q + 32'd2;
      h_valid_d       = 1'b0;
    end else if (w_valid_i) begin
      // 32-bit instruction straddling the word boundary.
      consume         = 1'b1;
      issue_valid_o   = 1'b1;
      issue_instr_o   = {w_data_i[15:0], h_data_q};
      issue_pc_o      = h_pc_q;
      issue_pc_next_o = h_pc_q + 32'd4;
      h_data_d        = w_data_i[31:16];
      h_pc_d          = w_hi_pc;
    end
  end

  assign w_consume_o = advance_i & consume;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_valid_q <= 1'b0;
      h_data_q  <= '0;
      h_pc_q    <= '0;
      offset_q  <= 1'b0;
    end else if (flush_i) begin
      h_valid_q <= 1'b0;
      offset_q  <= flush_offset_i;
    end else if (advance_i) begin
      h_valid_q <= h_valid_d;
      h_data_q  <= h_data_d;
      h_pc_q    <= h_pc_d;
      offset_q  <= offset_d;
    end
  end

endmodule

// File: rtl/pipeline_if_align.sv
// Instruction-fetch stage feeding decode. Owns the fetch address, replays
// responses the word register cannot accept, applies EXE/ID redirects and
// registers one realigned RV32IC instruction per cycle for ID.
//   clk, reset            : clock, asynchronous active-high reset
//   enable                : stage advance (low = stall)
//   redirect_e_i/pc       : EXE mispredict redirect and target
//   taken_d_i/redirection : ID static-prediction redirect and target
//   imem_addr_o           : word-aligned fetch address (combinational)
//   imem_rdata_i          : word for the address issued the previous cycle
//   instruction_f_o, pc_f_o, pc_plus4_f_o, instr_valid_f_o : registered to ID
module pipeline_if_align
  import pipeline_if_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        redirect_e_i,
  input  logic [31:0] redirect_pc_e_i,
  input  logic        taken_d_i,
  input  logic [31:0] redirection_d_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instruction_f_o,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc_plus4_f_o,
  output logic        instr_valid_f_o
);

  localparam logic [31:0] RESET_PC_NEXT = RESET_PC + 32'd4;

  redir_src_e  redir_src;
  logic [31:0] redir_target;
  logic        flush;
  logic        target_lsb_unused;

  logic [31:0] rsp_addr_q;
  logic        rsp_live_q;
  logic        w_valid_q;
  logic [31:0] w_data_q;
  logic [31:0] w_addr_q;
  logic        w_load;
  logic        w_consume;

  logic        issue_valid;
  logic [31:0] issue_instr;
  logic [31:0] issue_pc;
  logic [31:0] issue_pc_next;

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_next_q;
  logic        valid_q;

  always_comb begin
    redir_src    = REDIR_NONE;
    redir_target = redirect_pc_e_i;
    if (redirect_e_i) begin
      redir_src    = REDIR_EXE;
      redir_target = redirect_pc_e_i;
    end else if (taken_d_i && enable) begin
      redir_src    = REDIR_ID;
      redir_target = redirection_d_i;
    end
  end

  assign flush = (redir_src != REDIR_NONE);
  // RV32IC targets are halfword aligned; bit 0 carries no information.
  assign target_lsb_unused = redir_target[0];

  // A response is accepted only into an empty or just-emptied register;
  // otherwise the same address is issued again so no word is lost.
  assign w_load = rsp_live_q && (!w_valid_q || w_consume) && !flush;

  always_comb begin
    if (flush) begin
      imem_addr_o = {redir_target[31:2], 2'b00};
    end else if (w_load) begin
      imem_addr_o = rsp_addr_q + 32'd4;
    end else begin
      imem_addr_o = rsp_addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_addr_q <= RESET_PC;
      rsp_live_q <= 1'b0;
    end else begin
      rsp_addr_q <= imem_addr_o;
      rsp_live_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_addr_q  <= '0;
    end else if (flush) begin
      w_valid_q <= 1'b0;
    end else if (w_load) begin
      w_valid_q <= 1'b1;
      w_data_q  <= imem_rdata_i;
      w_addr_q  <= rsp_addr_q;
    end else if (w_consume) begin
      w_valid_q <= 1'b0;
    end
  end

  rvc_fetch_align #(
    .NOP_INSTR(NOP_INSTR)
  ) u_align (
    .clk_i          (clk),
    .rst_i          (reset),
    .advance_i      (enable && !flush),
    .flush_i        (flush),
    .flush_offset_i (redir_target[1]),
    .w_valid_i      (w_valid_q),
    .w_data_i       (w_data_q),
    .w_addr_i       (w_addr_q),
    .w_consume_o    (w_consume),
    .issue_valid_o  (issue_valid),
    .issue_instr_o  (issue_instr),
    .issue_pc_o     (issue_pc),
    .issue_pc_next_o(issue_pc_next)
  );

  // PC fields keep the last issued instruction's values while invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= RESET_PC;
      pc_next_q <= RESET_PC_NEXT;
      valid_q   <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (enable) begin
      valid_q <= issue_valid;
      if (issue_valid) begin
        instr_q   <= issue_instr;
        pc_q      <= issue_pc;
        pc_next_q <= issue_pc_next;
      end else begin
        instr_q <= NOP_INSTR;
      end
    end
  end

  assign instruction_f_o = instr_q;
  assign pc_f_o          = pc_q;
  assign pc_plus4_f_o    = pc_next_q;
  assign instr_valid_f_o = valid_q;

endmodule
